// File: rtl/rrv64_axi_peri_if.sv
// AXI4 slave-side bus plus the simple request/response backend port of the
// rrv64 peripheral responder, bundled so the top module stays compact.
interface rrv64_axi_peri_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) ();
    localparam int STRB_W = DATA_W / 8;

    // AW channel
    logic              aw_valid;
    logic              aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    // W channel
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;
    // B channel
    logic              b_valid;
    logic              b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    // AR channel
    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    // R channel
    logic              r_valid;
    logic              r_ready;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    // Backend
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last,
        input  r_ready,
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last,
        output r_ready,
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/rrv64_axi_peri_slave.sv
// AXI4 peripheral responder: one transaction in flight, each AXI beat turned
// into a single backend request. WRAP/reserved bursts and oversized beats are
// answered with SLVERR without touching the backend.
module rrv64_axi_peri_slave #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rrv64_axi_peri_if.slave       bus
);
    localparam int          STRB_W      = DATA_W / 8;
    localparam logic [2:0]  MAX_SIZE    = 3'($clog2(STRB_W));
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic        GRANT_READ  = 1'b0;
    localparam logic        GRANT_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_BEAT = 3'd1,
        S_WR_WAIT = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RD_DATA = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              bad_q, bad_d;
    logic              err_q, err_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              grant_wr_s, grant_rd_s, last_beat_s, aw_bad_s, ar_bad_s;
    logic [ADDR_W-1:0] next_addr_s;

    // Arbitration, burst legality and address stepping shared by the FSM
    always_comb begin
        grant_wr_s  = bus.aw_valid && (!bus.ar_valid || (grant_q == GRANT_READ));
        grant_rd_s  = bus.ar_valid && !grant_wr_s;
        last_beat_s = (cnt_q == 8'd0);
        aw_bad_s    = bus.aw_burst[1] || (bus.aw_size > MAX_SIZE);
        ar_bad_s    = bus.ar_burst[1] || (bus.ar_size > MAX_SIZE);
        if (burst_q == BURST_FIXED) begin
            next_addr_s = addr_q;
        end else begin
            next_addr_s = addr_q + (ADDR_W'(1) << size_q);
        end
    end

    assign bus.b_id   = id_q;
    assign bus.r_id   = id_q;
    assign bus.b_resp = err_q ? RESP_SLVERR : RESP_OKAY;
    assign bus.r_data = rdata_q;
    assign bus.r_resp = rresp_q;

    // Next-state and handshake decode for the transaction FSM
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        size_d        = size_q;
        burst_d       = burst_q;
        bad_d         = bad_q;
        err_d         = err_q;
        grant_d       = grant_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        bus.aw_ready  = 1'b0;
        bus.ar_ready  = 1'b0;
        bus.w_ready   = 1'b0;
        bus.b_valid   = 1'b0;
        bus.r_valid   = 1'b0;
        bus.r_last    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        case (state_q)
            S_IDLE: begin
                bus.aw_ready = grant_wr_s;
                bus.ar_ready = grant_rd_s;
                if (grant_wr_s) begin
                    id_d    = bus.aw_id;
                    addr_d  = bus.aw_addr;
                    cnt_d   = bus.aw_len;
                    size_d  = bus.aw_size;
                    burst_d = bus.aw_burst;
                    bad_d   = aw_bad_s;
                    err_d   = aw_bad_s;
                    state_d = S_WR_BEAT;
                end else if (grant_rd_s) begin
                    id_d    = bus.ar_id;
                    addr_d  = bus.ar_addr;
                    cnt_d   = bus.ar_len;
                    size_d  = bus.ar_size;
                    burst_d = bus.ar_burst;
                    bad_d   = ar_bad_s;
                    if (ar_bad_s) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = S_RD_DATA;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_BEAT: begin
                if (bad_q) begin
                    // Error burst: sink the data beats, never reach the backend
                    bus.w_ready = 1'b1;
                    if (bus.w_valid) begin
                        err_d = 1'b1;
                        if (last_beat_s) begin
                            state_d = S_WR_RESP;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end else begin
                        state_d = S_WR_BEAT;
                    end
                end else begin
                    bus.w_ready   = bus.req_ready;
                    bus.req_valid = bus.w_valid;
                    bus.req_we    = 1'b1;
                    bus.req_addr  = addr_q;
                    bus.req_wdata = bus.w_data;
                    bus.req_wstrb = bus.w_strb;
                    if (bus.w_valid && bus.req_ready) begin
                        err_d   = err_q | (bus.w_last != last_beat_s);
                        state_d = S_WR_WAIT;
                    end else begin
                        state_d = S_WR_BEAT;
                    end
                end
            end
            S_WR_WAIT: begin
                if (bus.rsp_valid) begin
                    err_d = err_q | bus.rsp_err;
                    if (last_beat_s) begin
                        state_d = S_WR_RESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr_s;
                        state_d = S_WR_BEAT;
                    end
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_RESP: begin
                bus.b_valid = 1'b1;
                if (bus.b_ready) begin
                    grant_d = GRANT_WRITE;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            S_RD_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_addr  = addr_q;
                if (bus.req_ready) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_WAIT: begin
                if (bus.rsp_valid) begin
                    rdata_d = bus.rsp_rdata;
                    rresp_d = bus.rsp_err ? RESP_SLVERR : RESP_OKAY;
                    state_d = S_RD_DATA;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_DATA: begin
                bus.r_valid = 1'b1;
                bus.r_last  = last_beat_s;
                if (bus.r_ready) begin
                    if (last_beat_s) begin
                        grant_d = GRANT_READ;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = next_addr_s;
                        if (bad_q) begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                            state_d = S_RD_DATA;
                        end else begin
                            state_d = S_RD_REQ;
                        end
                    end
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'b00;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= GRANT_READ;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end
endmodule

// File: tb/tb_rrv64_axi_peri_slave.sv
// Directed bench for rrv64_axi_peri_slave: drives AXI master traffic, models a
// one-cycle-latency backend, and checks responses against hand-computed values.
module tb_rrv64_axi_peri_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_req = 0;
    int   err_idx = -1;
    int   base;
    logic [39:0] log_addr[$];
    logic        log_we[$];

    rrv64_axi_peri_if #(.ADDR_W(40), .DATA_W(64), .ID_W(4)) bus ();

    rrv64_axi_peri_slave #(.ADDR_W(40), .DATA_W(64), .ID_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [39:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // Backend model: log each accepted request, answer it one cycle later
    always begin
        @(negedge clk);
        if (bus.req_valid && bus.req_ready) begin
            log_addr.push_back(bus.req_addr);
            log_we.push_back(bus.req_we);
            n_req = n_req + 1;
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = mk(log_addr[n_req-1]);
            bus.rsp_err   = ((n_req - 1) == err_idx);
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
            bus.rsp_err   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic aw(input logic [3:0] id, input logic [39:0] a, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.aw_id = id; bus.aw_addr = a; bus.aw_len = len; bus.aw_size = size;
        bus.aw_burst = burst; bus.aw_valid = 1'b1;
        settle();
        chk("aw_ready", 64'(bus.aw_ready), 64'd1);
        tick();
        bus.aw_valid = 1'b0;
    endtask

    task automatic ar(input logic [3:0] id, input logic [39:0] a, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        bus.ar_id = id; bus.ar_addr = a; bus.ar_len = len; bus.ar_size = size;
        bus.ar_burst = burst; bus.ar_valid = 1'b1;
        settle();
        chk("ar_ready", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.ar_valid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic last);
        int k = 0;
        bus.w_valid = 1'b1; bus.w_data = d; bus.w_strb = 8'hFF; bus.w_last = last;
        settle();
        while (!bus.w_ready && k < 40) begin
            tick();
            k++;
        end
        chk("w_ready_wait", 64'(bus.w_ready), 64'd1);
        tick();
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
    endtask

    task automatic b_take(input string tag, input logic [1:0] resp, input logic [3:0] id);
        int k = 0;
        while (!bus.b_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_bvalid"}, 64'(bus.b_valid), 64'd1);
        chk({tag, "_bresp"}, 64'(bus.b_resp), 64'(resp));
        chk({tag, "_bid"}, 64'(bus.b_id), 64'(id));
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        settle();
        chk({tag, "_bvalid_drop"}, 64'(bus.b_valid), 64'd0);
    endtask

    task automatic r_take(input string tag, input logic [63:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id, input logic bp);
        int k = 0;
        while (!bus.r_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_rvalid"}, 64'(bus.r_valid), 64'd1);
        chk({tag, "_rdata"}, bus.r_data, d);
        chk({tag, "_rresp"}, 64'(bus.r_resp), 64'(resp));
        chk({tag, "_rlast"}, 64'(bus.r_last), 64'(last));
        chk({tag, "_rid"}, 64'(bus.r_id), 64'(id));
        if (bp) begin
            bus.r_ready = 1'b0;
            tick();
            chk({tag, "_hold_valid"}, 64'(bus.r_valid), 64'd1);
            chk({tag, "_hold_data"}, bus.r_data, d);
        end
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        bus.aw_valid = 1'b0; bus.aw_id = 4'd0; bus.aw_addr = 40'd0; bus.aw_len = 8'd0;
        bus.aw_size = 3'd0; bus.aw_burst = 2'b00;
        bus.w_valid = 1'b0; bus.w_data = 64'd0; bus.w_strb = 8'h00; bus.w_last = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_id = 4'd0; bus.ar_addr = 40'd0; bus.ar_len = 8'd0;
        bus.ar_size = 3'd0; bus.ar_burst = 2'b00;
        bus.r_ready = 1'b0;
        bus.req_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_rdata = 64'd0; bus.rsp_err = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_b_valid", 64'(bus.b_valid), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_r_last", 64'(bus.r_last), 64'd0);
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_b_resp", 64'(bus.b_resp), 64'd0);
        chk("rst_r_resp", 64'(bus.r_resp), 64'd0);
        chk("rst_r_data", bus.r_data, 64'd0);
        chk("rst_b_id", 64'(bus.b_id), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single write, len 0
        aw(4'd5, 40'h1000, 8'd0, 3'd3, 2'b01);
        bus.w_valid = 1'b1; bus.w_data = 64'h1122_3344_5566_7788; bus.w_strb = 8'hFF;
        bus.w_last = 1'b1;
        settle();
        chk("sw_req_valid", 64'(bus.req_valid), 64'd1);
        chk("sw_req_we", 64'(bus.req_we), 64'd1);
        chk("sw_req_addr", 64'(bus.req_addr), 64'h1000);
        chk("sw_req_wdata", bus.req_wdata, 64'h1122_3344_5566_7788);
        chk("sw_req_wstrb", 64'(bus.req_wstrb), 64'hFF);
        tick();
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        b_take("sw", 2'b00, 4'd5);
        chk("sw_nreq", 64'(n_req), 64'd1);

        // Read burst len 3 with r_ready backpressure
        base = n_req;
        ar(4'd3, 40'h2000, 8'd3, 3'd3, 2'b01);
        for (int k = 0; k < 4; k++) begin
            r_take("rb", mk(40'h2000 + 40'(8 * k)), 2'b00, (k == 3), 4'd3, 1'b1);
        end
        settle();
        chk("rb_rvalid_end", 64'(bus.r_valid), 64'd0);
        chk("rb_nreq", 64'(n_req - base), 64'd4);
        chk("rb_addr1", 64'(log_addr[base+1]), 64'h2008);
        chk("rb_addr3", 64'(log_addr[base+3]), 64'h2018);
        chk("rb_we", 64'(log_we[base]), 64'd0);

        // Tie after reset: write first, then read
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.aw_id = 4'd1; bus.aw_addr = 40'h3000; bus.aw_len = 8'd0; bus.aw_size = 3'd3;
        bus.aw_burst = 2'b01; bus.aw_valid = 1'b1;
        bus.ar_id = 4'd6; bus.ar_addr = 40'h3100; bus.ar_len = 8'd0; bus.ar_size = 3'd3;
        bus.ar_burst = 2'b01; bus.ar_valid = 1'b1;
        settle();
        chk("tie1_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("tie1_ar_ready", 64'(bus.ar_ready), 64'd0);
        tick();
        bus.aw_valid = 1'b0;
        settle();
        chk("tie1_ar_blocked", 64'(bus.ar_ready), 64'd0);
        w_beat(64'hAAAA_5555_AAAA_5555, 1'b1);
        b_take("tie1", 2'b00, 4'd1);
        bus.aw_valid = 1'b1;
        settle();
        chk("tie2_ar_ready", 64'(bus.ar_ready), 64'd1);
        chk("tie2_aw_ready", 64'(bus.aw_ready), 64'd0);
        tick();
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        r_take("tie2", mk(40'h3100), 2'b00, 1'b1, 4'd6, 1'b0);

        // Write len 1 with backend error on beat 0
        base = n_req;
        err_idx = n_req;
        aw(4'd4, 40'h4000, 8'd1, 3'd3, 2'b01);
        w_beat(64'h0101_0101_0101_0101, 1'b0);
        w_beat(64'h0202_0202_0202_0202, 1'b1);
        b_take("werr", 2'b10, 4'd4);
        err_idx = -1;
        chk("werr_nreq", 64'(n_req - base), 64'd2);
        chk("werr_addr0", 64'(log_addr[base]), 64'h4000);
        chk("werr_addr1", 64'(log_addr[base+1]), 64'h4008);

        // Oversized write beat: SLVERR without backend traffic
        base = n_req;
        aw(4'd9, 40'h7000, 8'd0, 3'd4, 2'b01);
        w_beat(64'h0303_0303_0303_0303, 1'b1);
        b_take("wbig", 2'b10, 4'd9);
        chk("wbig_nreq", 64'(n_req - base), 64'd0);

        // WRAP read: two SLVERR beats, zero data, no backend traffic
        base = n_req;
        ar(4'd7, 40'h8000, 8'd1, 3'd3, 2'b10);
        r_take("wrap0", 64'd0, 2'b10, 1'b0, 4'd7, 1'b0);
        r_take("wrap1", 64'd0, 2'b10, 1'b1, 4'd7, 1'b0);
        chk("wrap_nreq", 64'(n_req - base), 64'd0);

        // Reset while presenting read data abandons the burst
        ar(4'd2, 40'h5000, 8'd1, 3'd3, 2'b01);
        begin
            int k = 0;
            while (!bus.r_valid && k < 40) begin
                tick();
                k++;
            end
        end
        chk("rst_mid_rdata", bus.r_data, mk(40'h5000));
        rst_n = 1'b0;
        bus.ar_id = 4'd8; bus.ar_addr = 40'h6000; bus.ar_len = 8'd0; bus.ar_burst = 2'b01;
        bus.ar_valid = 1'b1;
        tick();
        chk("rst_mid_rvalid", 64'(bus.r_valid), 64'd0);
        chk("rst_mid_ar_ready", 64'(bus.ar_ready), 64'd1);
        bus.ar_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rst_mid_no_r", 64'(bus.r_valid), 64'd0);
        chk("rst_mid_no_b", 64'(bus.b_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
